wb_mem_arbiter: RTL

- Round-robin Wishbone B3 arbiter that shares the single wb_bfm_memory slave port of orpsoc_top between several masters.
- Masters are the mor1kx instruction bus, the mor1kx data bus and the JTAG debug unit.
- Sits between the masters and the memory's slave port.
- Grant is held for a whole bus cycle (cyc high), including registered bursts (cti/bte passthrough).

---
 rtl/wb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one memory slave port between NUM_MASTERS masters.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN (adds the timeout_o port).
module wb_mem_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 256
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*(DW/8)-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
    output logic [DW-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [NUM_MASTERS-1:0]        m_rty_o,
    output logic [AW-1:0]                 s_adr_o,
    output logic [DW-1:0]                 s_dat_o,
    output logic [DW/8-1:0]               s_sel_o,
    output logic                          s_we_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic [2:0]                    s_cti_o,
    output logic [1:0]                    s_bte_o,
    input  logic [DW-1:0]                 s_dat_i,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    input  logic                          s_rty_i,
`ifdef WB_ARB_TIMEOUT_EN
    output logic                          timeout_o,
`endif
    output logic [NUM_MASTERS-1:0]        grant_o
);

    localparam int SW = DW / 8;
    localparam int LW = $clog2(NUM_MASTERS);

    generate
        if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || (DW % 8) != 0 || TIMEOUT < 2) begin : g_param_check
            $error("wb_mem_arbiter: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [LW-1:0]            last_q, last_d;

    logic [NUM_MASTERS-1:0]   pick_oh;
    logic [LW-1:0]            pick_idx;
    int                       idx;

    logic [AW-1:0]            g_adr;
    logic [DW-1:0]            g_dat;
    logic [SW-1:0]            g_sel;
    logic                     g_we;
    logic                     g_cyc;
    logic                     g_stb;
    logic [2:0]               g_cti;
    logic [1:0]               g_bte;

    logic                     term;

    assign term    = s_ack_i | s_err_i | s_rty_i;
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    // Round-robin pick: scan downward so the requester nearest after last_q wins.
    always_comb begin
        pick_oh  = '0;
        pick_idx = last_q;
        idx      = 0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = (int'(last_q) + i) % NUM_MASTERS;
            if (m_cyc_i[idx[LW-1:0]]) begin
                pick_oh              = '0;
                pick_oh[idx[LW-1:0]] = 1'b1;
                pick_idx             = idx[LW-1:0];
            end
        end
    end

    // AND-OR mux of the granted master; an empty grant yields all zeros.
    always_comb begin
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_we  = 1'b0;
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_cti = '0;
        g_bte = '0;
        for (int n = 0; n < NUM_MASTERS; n++) begin
            if (grant_q[n]) begin
                g_adr = g_adr | m_adr_i[n*AW +: AW];
                g_dat = g_dat | m_dat_i[n*DW +: DW];
                g_sel = g_sel | m_sel_i[n*SW +: SW];
                g_we  = g_we  | m_we_i[n];
                g_cyc = g_cyc | m_cyc_i[n];
                g_stb = g_stb | m_stb_i[n];
                g_cti = g_cti | m_cti_i[n*3 +: 3];
                g_bte = g_bte | m_bte_i[n*2 +: 2];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_hit;

    assign tmo_hit = (state_q == BUSY) && g_cyc && g_stb && !term &&
                     (cnt_q == CW'(TIMEOUT - 1));

    // Counts stalled strobe cycles; holds while the master idles its strobe.
    always_comb begin
        cnt_d = '0;
        if (state_q == BUSY && g_cyc && !term) begin
            cnt_d = g_stb ? cnt_q + 1'b1 : cnt_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (|m_cyc_i) begin
                    grant_d = pick_oh;
                    last_d  = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = ABORT;
                end
`endif
            end
            ABORT: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
`ifdef WB_ARB_TIMEOUT_EN
        timeout_o = 1'b0;
`endif
        if (state_q == BUSY) begin
            s_adr_o = g_adr;
            s_dat_o = g_dat;
            s_sel_o = g_sel;
            s_we_o  = g_we;
            s_cyc_o = g_cyc;
            s_stb_o = g_stb & g_cyc;
            s_cti_o = g_cti;
            s_bte_o = g_bte;
            // Terminations are suppressed during reset so an aborted cycle never completes.
            if (!wb_rst_i) begin
                m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
                m_err_o = grant_q & {NUM_MASTERS{s_err_i}};
                m_rty_o = grant_q & {NUM_MASTERS{s_rty_i}};
            end
        end
`ifdef WB_ARB_TIMEOUT_EN
        if (state_q == ABORT && !wb_rst_i) begin
            m_err_o   = grant_q;
            timeout_o = 1'b1;
        end
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule
